// File: rtl/apmu_csr_pkg.sv
// ----------------------------------------------------------------------------
// apmu_csr_pkg: shared types and the write-mask merge for CSR access control.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apmu_csr_pkg;

  localparam int CSR_MAX_WIDTH = 64;

  typedef logic [CSR_MAX_WIDTH-1:0] csr_word_t;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_RESP   = 3'd4
  } csr_acc_state_e;

  // Read-only bits (mask clear) always keep the old value, whatever the op.
  function automatic csr_word_t csr_apply_op(csr_op_e op, csr_word_t old_val,
                                             csr_word_t data, csr_word_t mask);
    csr_word_t mod_val;
    case (op)
      CSR_OP_WRITE: mod_val = data;
      CSR_OP_SET:   mod_val = old_val | data;
      CSR_OP_CLEAR: mod_val = old_val & ~data;
      default:      mod_val = old_val;
    endcase
    return (old_val & ~mask) | (mod_val & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apmu_csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// apmu_csr_access_ctrl: sequences atomic READ/WRITE/SET/CLEAR ops onto one CSR.
// Optional post-write readback check: define APMU_CSR_ACC_VERIFY_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apmu_csr_access_ctrl
  import apmu_csr_pkg::*;
#(
  parameter int               Width        = 32,
  parameter logic [Width-1:0] WritableMask = '1,
  parameter int               ErrCntWidth  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  csr_op_e                req_op_i,
  input  logic [Width-1:0]       req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [Width-1:0]       rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   csr_wr_en_o,
  output logic [Width-1:0]       csr_wr_data_o,
  input  logic [Width-1:0]       csr_rd_data_i,
  input  logic                   csr_rd_error_i,
  output logic [ErrCntWidth-1:0] err_count_o
);

  csr_acc_state_e   r_state;
  csr_op_e          r_op;
  logic [Width-1:0] r_data;
  logic [Width-1:0] w_new;

  assign w_new = Width'(csr_apply_op(r_op, csr_word_t'(csr_rd_data_i),
                                     csr_word_t'(r_data), csr_word_t'(WritableMask)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_op          <= CSR_OP_READ;
      r_data        <= '0;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      csr_wr_en_o   <= 1'b0;
      csr_wr_data_o <= '0;
      err_count_o   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_op        <= req_op_i;
            r_data      <= req_data_i;
            req_ready_o <= 1'b0;
            r_state     <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          rsp_rdata_o <= csr_rd_data_i;
          rsp_error_o <= csr_rd_error_i;
          // A corrupted CSR is never written back; the op degrades to a read.
          if (r_op == CSR_OP_READ || csr_rd_error_i) begin
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            csr_wr_en_o   <= 1'b1;
            csr_wr_data_o <= w_new;
            r_state       <= ST_WRITE;
          end
        end
`ifdef APMU_CSR_ACC_VERIFY_EN
        ST_WRITE: begin
          csr_wr_en_o <= 1'b0;
          r_state     <= ST_VERIFY;
        end
        ST_VERIFY: begin
          // csr_wr_data_o still holds the value just written.
          if (csr_rd_error_i || (csr_rd_data_i != csr_wr_data_o)) begin
            rsp_error_o <= 1'b1;
          end
          rsp_valid_o <= 1'b1;
          r_state     <= ST_RESP;
        end
`else
        ST_WRITE: begin
          csr_wr_en_o <= 1'b0;
          rsp_valid_o <= 1'b1;
          r_state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready_i) begin
            if (rsp_error_o && (err_count_o != {ErrCntWidth{1'b1}})) begin
              err_count_o <= err_count_o + ErrCntWidth'(1);
            end
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          csr_wr_en_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apmu_csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apmu_csr_access_ctrl: randomized bench with a CSR model and a reference
// predictor for apmu_csr_access_ctrl (default build).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_apmu_csr_access_ctrl;
  import apmu_csr_pkg::*;

  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  csr_op_e     req_op = CSR_OP_READ;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        csr_wr_en;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_q = '0;
  logic        csr_rd_error = 1'b0;
  logic [7:0]  err_count;

  logic        preload_en = 1'b0;
  logic [31:0] preload_val = '0;
  int unsigned wr_cnt = 0;
  logic [31:0] last_wr = '0;

  int n_checks = 0;
  int n_errors = 0;
  int model_err = 0;

  always #5 clk = ~clk;

  apmu_csr_access_ctrl #(
    .Width(32), .WritableMask(MASK), .ErrCntWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .csr_wr_en_o(csr_wr_en), .csr_wr_data_o(csr_wr_data),
    .csr_rd_data_i(csr_q), .csr_rd_error_i(csr_rd_error),
    .err_count_o(err_count)
  );

  // The CSR being driven: takes the write strobe, or a bench preload.
  always @(posedge clk) begin
    if (preload_en) csr_q <= preload_val;
    else if (csr_wr_en) csr_q <= csr_wr_data;
    if (csr_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= csr_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_csr(input logic [31:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // One full transaction; called at a negedge with the DUT idle.
  task automatic do_op(input csr_op_e op, input logic [31:0] data, input bit inj, input int hold);
    logic [31:0] old_v, mod_v, new_v, rd_hold;
    int unsigned wr0;
    bit is_wr;
    int lat;
    old_v = csr_q;
    case (op)
      CSR_OP_WRITE: mod_v = data;
      CSR_OP_SET:   mod_v = old_v | data;
      CSR_OP_CLEAR: mod_v = old_v & ~data;
      default:      mod_v = old_v;
    endcase
    new_v = (old_v & ~MASK) | (mod_v & MASK);
    is_wr = (op != CSR_OP_READ) && !inj;
    wr0   = wr_cnt;

    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_data     = data;
    csr_rd_error = inj;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    csr_rd_error = 1'b0;
    chk("latency", lat, is_wr ? 32'd3 : 32'd2);
    chk("rsp_rdata", rsp_rdata, old_v);
    chk("rsp_error", {31'b0, rsp_error}, {31'b0, inj});
    chk("wr_strobes", wr_cnt - wr0, is_wr ? 32'd1 : 32'd0);
    if (is_wr) chk("wr_data", last_wr, new_v);
    chk("csr_after", csr_q, is_wr ? new_v : old_v);

    rd_hold = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = csr_op_e'($urandom_range(3));
      req_data  = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd_hold);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (inj && model_err < 255) model_err++;
    chk("err_count", {24'b0, err_count}, model_err);
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    chk("no_extra_wr", wr_cnt - wr0, is_wr ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [31:0] rand_data;
    int unsigned wr0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wr_en", {31'b0, csr_wr_en}, 32'd0);
    chk("rst_wr_data", csr_wr_data, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);

    set_csr(32'hA5A5_0001);
    do_op(CSR_OP_READ, 32'h0, 1'b0, 0);
    set_csr(32'hDEAD_0000);
    do_op(CSR_OP_WRITE, 32'h1234_5678, 1'b0, 0);
    set_csr(32'h0000_000F);
    do_op(CSR_OP_SET, 32'h0000_00F0, 1'b0, 0);
    do_op(CSR_OP_CLEAR, 32'h0000_000F, 1'b0, 1);
    do_op(CSR_OP_WRITE, 32'h0000_00F0, 1'b0, 0);
    do_op(CSR_OP_WRITE, 32'hCAFE_BEEF, 1'b1, 5);

    for (int n = 0; n < 150; n++) begin
      rand_data = $urandom;
      if ($urandom_range(7) == 0) set_csr($urandom);
      do_op(csr_op_e'($urandom_range(3)), rand_data, ($urandom_range(9) == 0),
            int'($urandom_range(3)));
    end

    for (int n = 0; n < 300; n++) begin
      do_op(csr_op_e'($urandom_range(1, 3)), $urandom, 1'b1, 0);
    end
    chk("err_saturated", {24'b0, err_count}, 32'h0000_00FF);

    set_csr(32'h0000_0000);
    wr0 = wr_cnt;
    req_valid = 1'b1;
    req_op    = CSR_OP_WRITE;
    req_data  = 32'h0000_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", {31'b0, csr_wr_en}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_rsp_error", {31'b0, rsp_error}, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    chk("midrst_wr_data", csr_wr_data, 32'd0);
    chk("midrst_err_count", {24'b0, err_count}, 32'd0);
    rst = 1'b0;
    model_err = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_wr", wr_cnt - wr0, 32'd0);
    do_op(CSR_OP_SET, 32'h0000_0101, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
